regfile_sb: RTL and testbench

- Parametrised, clocked successor to the CPU general-purpose register file.
- Two combinational read ports and one synchronous write port, with optional write-to-read bypass.
- Per-register pending scoreboard that the pipeline uses for RAW hazard detection.
- Registered syscall tap: v0 is read live; a0 is captured on a print request and qualified by a one-cycle valid pulse.

---
 rtl/regfile_sb.sv | 110 +++++++++++
 tb/tb_regfile_sb.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// General-purpose register file: two combinational read ports, one write port,
// optional write-first bypass, per-register pending scoreboard and syscall tap.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1,
    parameter int V0_IDX = 2,
    parameter int A0_IDX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              busy_a,
    output logic              busy_b,
    output logic [DATA_W-1:0] sys_v0,
    input  logic              print_req,
    output logic [DATA_W-1:0] sys_a0,
    output logic              sys_a0_vld
);

    localparam int              DEPTH  = 1 << ADDR_W;
    localparam bit              LP_BYP = (BYPASS != 0);
    localparam logic [ADDR_W-1:0] LP_V0 = V0_IDX[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] LP_A0 = A0_IDX[ADDR_W-1:0];

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_pend;
    logic [DATA_W-1:0] r_sys_a0;
    logic              r_sys_a0_vld;

    logic              w_wr_ok;
    logic              w_hit_a;
    logic              w_hit_b;
    logic              w_hit_a0;
    logic [DATA_W-1:0] w_a0_val;
    logic [DEPTH-1:0]  w_pend_nxt;

    assign w_wr_ok  = wr_en && (wr_addr != '0);
    assign w_hit_a  = LP_BYP && w_wr_ok && (wr_addr == rd_addr_a);
    assign w_hit_b  = LP_BYP && w_wr_ok && (wr_addr == rd_addr_b);
    assign w_hit_a0 = LP_BYP && w_wr_ok && (wr_addr == LP_A0);

    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        busy_a    = 1'b0;
        busy_b    = 1'b0;
        sys_v0    = '0;
        w_a0_val  = '0;
        if (rd_addr_a != '0) begin
            rd_data_a = w_hit_a ? wr_data : r_regs[rd_addr_a];
            busy_a    = w_hit_a ? 1'b0 : r_pend[rd_addr_a];
        end
        if (rd_addr_b != '0) begin
            rd_data_b = w_hit_b ? wr_data : r_regs[rd_addr_b];
            busy_b    = w_hit_b ? 1'b0 : r_pend[rd_addr_b];
        end
        // sys_v0 is a raw tap of storage; it never sees the bypass path
        if (LP_V0 != '0) begin
            sys_v0 = r_regs[LP_V0];
        end
        if (LP_A0 != '0) begin
            w_a0_val = w_hit_a0 ? wr_data : r_regs[LP_A0];
        end
    end

    // Issue is applied after writeback clear: a same-cycle issue is the newer producer
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_wr_ok) begin
            w_pend_nxt[wr_addr] = 1'b0;
        end
        if (iss_en && (iss_addr != '0)) begin
            w_pend_nxt[iss_addr] = 1'b1;
        end
        w_pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_pend       <= '0;
            r_sys_a0     <= '0;
            r_sys_a0_vld <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_regs[wr_addr] <= wr_data;
            end
            r_pend       <= w_pend_nxt;
            r_sys_a0_vld <= print_req;
            if (print_req) begin
                r_sys_a0 <= w_a0_val;
            end
        end
    end

    assign sys_a0     = r_sys_a0;
    assign sys_a0_vld = r_sys_a0_vld;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one bypassing and one non-bypassing instance
// share every input so write-first and read-old behaviour are compared side by side.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_addr_a, rd_addr_b, wr_addr, iss_addr;
    logic [31:0] wr_data;
    logic        wr_en, iss_en, print_req;

    logic [31:0] rda1, rdb1, v01, a01, rda0, rdb0, v00, a00;
    logic        ba1, bb1, vld1, ba0, bb0, vld0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1), .V0_IDX(2), .A0_IDX(4)) u_dut1 (
        .clk(clk), .rst(rst),
        .rd_addr_a(rd_addr_a), .rd_data_a(rda1),
        .rd_addr_b(rd_addr_b), .rd_data_b(rdb1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .busy_a(ba1), .busy_b(bb1),
        .sys_v0(v01), .print_req(print_req), .sys_a0(a01), .sys_a0_vld(vld1)
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(0), .V0_IDX(2), .A0_IDX(4)) u_dut0 (
        .clk(clk), .rst(rst),
        .rd_addr_a(rd_addr_a), .rd_data_a(rda0),
        .rd_addr_b(rd_addr_b), .rd_data_b(rdb0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .busy_a(ba0), .busy_b(bb0),
        .sys_v0(v00), .print_req(print_req), .sys_a0(a00), .sys_a0_vld(vld0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; iss_en = 1'b0; print_req = 1'b0; rst = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        wr(5'd5, 32'd55);
        wr(5'd7, 32'd77);
        wr(5'd4, 32'd44);
        iss_en = 1'b1; iss_addr = 5'd9;
        tick();
        iss_en = 1'b0;
        rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hFFFF_FFFF;
        iss_en = 1'b1; iss_addr = 5'd6; print_req = 1'b1;
        tick();
        idle();
        rd_addr_a = 5'd5; rd_addr_b = 5'd7;
        #1;
        checks++; if (rda1 !== 32'd0) begin errors++; $display("FAIL rst_reg5_b1 got=%h exp=0", rda1); end
        checks++; if (rda0 !== 32'd0) begin errors++; $display("FAIL rst_reg5_b0 got=%h exp=0", rda0); end
        checks++; if (rdb1 !== 32'd0) begin errors++; $display("FAIL rst_reg7 got=%h exp=0", rdb1); end
        rd_addr_a = 5'd9; rd_addr_b = 5'd6;
        #1;
        checks++; if (ba1 !== 1'b0 || ba0 !== 1'b0) begin errors++; $display("FAIL rst_busy9 got=%b%b exp=00", ba1, ba0); end
        checks++; if (bb1 !== 1'b0 || bb0 !== 1'b0) begin errors++; $display("FAIL rst_busy6 got=%b%b exp=00", bb1, bb0); end
        checks++; if (a01 !== 32'd0 || a00 !== 32'd0) begin errors++; $display("FAIL rst_sys_a0 got=%h/%h exp=0", a01, a00); end
        checks++; if (vld1 !== 1'b0 || vld0 !== 1'b0) begin errors++; $display("FAIL rst_vld got=%b%b exp=00", vld1, vld0); end
        rd_addr_a = 5'd4;
        #1;
        checks++; if (rda1 !== 32'd0) begin errors++; $display("FAIL rst_reg4 got=%h exp=0", rda1); end
    endtask

    task automatic test_write_zero();
        rd_addr_a = 5'd7; rd_addr_b = 5'd0;
        wr(5'd7, 32'hDEAD_BEEF);
        checks++; if (rda1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr7_b1 got=%h exp=deadbeef", rda1); end
        checks++; if (rda0 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr7_b0 got=%h exp=deadbeef", rda0); end
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234_5678; rd_addr_a = 5'd0;
        #1;
        checks++; if (rdb1 !== 32'd0 || rda1 !== 32'd0) begin errors++; $display("FAIL wr0_bypass got=%h/%h exp=0", rda1, rdb1); end
        tick();
        wr_en = 1'b0;
        #1;
        checks++; if (rdb1 !== 32'd0 || rdb0 !== 32'd0) begin errors++; $display("FAIL wr0_after got=%h/%h exp=0", rdb1, rdb0); end
    endtask

    task automatic test_bypass();
        wr(5'd3, 32'd1);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5_A5A5; rd_addr_a = 5'd3;
        #1;
        checks++; if (rda1 !== 32'hA5A5_A5A5) begin errors++; $display("FAIL byp1_same got=%h exp=a5a5a5a5", rda1); end
        checks++; if (rda0 !== 32'd1) begin errors++; $display("FAIL byp0_same got=%h exp=1", rda0); end
        tick();
        wr_en = 1'b0;
        #1;
        checks++; if (rda1 !== 32'hA5A5_A5A5) begin errors++; $display("FAIL byp1_after got=%h exp=a5a5a5a5", rda1); end
        checks++; if (rda0 !== 32'hA5A5_A5A5) begin errors++; $display("FAIL byp0_after got=%h exp=a5a5a5a5", rda0); end
    endtask

    task automatic test_scoreboard();
        iss_en = 1'b1; iss_addr = 5'd9; rd_addr_a = 5'd9;
        #1;
        checks++; if (ba1 !== 1'b0 || ba0 !== 1'b0) begin errors++; $display("FAIL iss_same_cycle got=%b%b exp=00", ba1, ba0); end
        tick();
        iss_en = 1'b0;
        #1;
        checks++; if (ba1 !== 1'b1 || ba0 !== 1'b1) begin errors++; $display("FAIL iss_busy got=%b%b exp=11", ba1, ba0); end
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'd99; iss_en = 1'b1; iss_addr = 5'd9;
        #1;
        checks++; if (ba1 !== 1'b0) begin errors++; $display("FAIL wr_iss_busy_byp1 got=%b exp=0", ba1); end
        checks++; if (ba0 !== 1'b1) begin errors++; $display("FAIL wr_iss_busy_byp0 got=%b exp=1", ba0); end
        tick();
        wr_en = 1'b0; iss_en = 1'b0;
        #1;
        checks++; if (ba1 !== 1'b1 || ba0 !== 1'b1) begin errors++; $display("FAIL wr_iss_pending got=%b%b exp=11", ba1, ba0); end
        checks++; if (rda1 !== 32'd99 || rda0 !== 32'd99) begin errors++; $display("FAIL wr_iss_data got=%h/%h exp=63", rda1, rda0); end
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'd100; iss_en = 1'b1; iss_addr = 5'd10; rd_addr_b = 5'd10;
        tick();
        wr_en = 1'b0; iss_en = 1'b0;
        #1;
        checks++; if (ba1 !== 1'b0 || ba0 !== 1'b0) begin errors++; $display("FAIL wr_clear got=%b%b exp=00", ba1, ba0); end
        checks++; if (bb1 !== 1'b1 || bb0 !== 1'b1) begin errors++; $display("FAIL iss_other got=%b%b exp=11", bb1, bb0); end
        iss_en = 1'b1; iss_addr = 5'd10;
        tick();
        iss_en = 1'b0;
        wr(5'd10, 32'd7);
        checks++; if (bb1 !== 1'b0 || bb0 !== 1'b0) begin errors++; $display("FAIL reissue_no_count got=%b%b exp=00", bb1, bb0); end
        iss_en = 1'b1; iss_addr = 5'd0; rd_addr_b = 5'd0;
        tick();
        iss_en = 1'b0;
        checks++; if (bb1 !== 1'b0 || bb0 !== 1'b0) begin errors++; $display("FAIL iss_zero got=%b%b exp=00", bb1, bb0); end
    endtask

    task automatic test_syscall();
        wr(5'd2, 32'd10);
        wr(5'd4, 32'd42);
        print_req = 1'b1;
        tick();
        print_req = 1'b0;
        checks++; if (v01 !== 32'd10 || v00 !== 32'd10) begin errors++; $display("FAIL sys_v0 got=%0d/%0d exp=10", v01, v00); end
        checks++; if (a01 !== 32'd42 || a00 !== 32'd42) begin errors++; $display("FAIL sys_a0 got=%0d/%0d exp=42", a01, a00); end
        checks++; if (vld1 !== 1'b1 || vld0 !== 1'b1) begin errors++; $display("FAIL sys_vld_hi got=%b%b exp=11", vld1, vld0); end
        tick();
        checks++; if (vld1 !== 1'b0 || vld0 !== 1'b0) begin errors++; $display("FAIL sys_vld_lo got=%b%b exp=00", vld1, vld0); end
        checks++; if (a01 !== 32'd42 || a00 !== 32'd42) begin errors++; $display("FAIL sys_a0_hold got=%0d/%0d exp=42", a01, a00); end
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'd11;
        #1;
        checks++; if (v01 !== 32'd10) begin errors++; $display("FAIL sys_v0_nobyp got=%0d exp=10", v01); end
        tick();
        wr_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        print_req = 1'b1; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'd43;
        tick();
        wr_en = 1'b0;
        checks++; if (vld1 !== 1'b1 || vld0 !== 1'b1) begin errors++; $display("FAIL b2b_vld1 got=%b%b exp=11", vld1, vld0); end
        checks++; if (a01 !== 32'd43) begin errors++; $display("FAIL b2b_first_byp1 got=%0d exp=43", a01); end
        checks++; if (a00 !== 32'd42) begin errors++; $display("FAIL b2b_first_byp0 got=%0d exp=42", a00); end
        tick();
        print_req = 1'b0;
        checks++; if (vld1 !== 1'b1 || vld0 !== 1'b1) begin errors++; $display("FAIL b2b_vld2 got=%b%b exp=11", vld1, vld0); end
        checks++; if (a01 !== 32'd43 || a00 !== 32'd43) begin errors++; $display("FAIL b2b_second got=%0d/%0d exp=43", a01, a00); end
        tick();
        checks++; if (vld1 !== 1'b0 || vld0 !== 1'b0) begin errors++; $display("FAIL b2b_vld_end got=%b%b exp=00", vld1, vld0); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rst = 1'b1;
        rd_addr_a = '0; rd_addr_b = '0; wr_addr = '0; iss_addr = '0; wr_data = '0;
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_write_zero();
        test_bypass();
        test_scoreboard();
        test_syscall();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
